// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store initiator with byte-lane masking and load extension.
// Define LSU_MISALIGN_SPLIT_EN to allow misaligned accesses (word-crossing ones split in two).
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_store,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_wmask,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
    state_t state;
    logic store_q, split_q;
    logic [2:0] funct3_q;
    logic [1:0] off_q;
    logic [3:0] hi_mask_q;
    logic [WIDTH-1:0] hi_wdata_q, asm_q, raw, ext;
    logic [1:0] off;
    logic [2:0] sz;
    logic [3:0] base;
    logic [7:0] lanes;
    logic [2*WIDTH-1:0] shifted;
    logic bad, misalign, split;
    assign req_ready = state == IDLE && !rst;
    always_comb begin
        off = req_addr[1:0];
        sz = req_funct3[1:0] == 2'b00 ? 3'd1 : req_funct3[1:0] == 2'b01 ? 3'd2 : 3'd4;
        base = req_funct3[1:0] == 2'b00 ? 4'b0001 : req_funct3[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
        // upper nibble/word feed the second access of a word-crossing store
        lanes = {4'b0000, base} << off;
        shifted = {{WIDTH{1'b0}}, req_wdata} << {off, 3'b000};
        bad = (&req_funct3[1:0]) | (req_store ? req_funct3[2] : req_funct3 == 3'b110);
`ifdef LSU_MISALIGN_SPLIT_EN
        split = {1'b0, off} + sz > 3'd4;
        misalign = 1'b0;
`else
        split = 1'b0;
        misalign = (sz == 3'd2 && off[0]) || (sz == 3'd4 && off != 2'b00);
`endif
        raw = state == ACC1 ? asm_q | (mem_rdata << {3'd4 - {1'b0, off_q}, 3'b000})
                            : mem_rdata >> {off_q, 3'b000};
        ext = store_q ? '0 :
              funct3_q == 3'b000 ? {{24{raw[7]}}, raw[7:0]} :
              funct3_q == 3'b001 ? {{16{raw[15]}}, raw[15:0]} :
              funct3_q == 3'b100 ? {24'b0, raw[7:0]} :
              funct3_q == 3'b101 ? {16'b0, raw[15:0]} : raw;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            store_q <= 1'b0;
            split_q <= 1'b0;
            funct3_q <= 3'b000;
            off_q <= 2'b00;
            hi_mask_q <= 4'b0000;
            hi_wdata_q <= '0;
            asm_q <= '0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wmask <= 4'b0000;
            mem_wdata <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    store_q <= req_store;
                    funct3_q <= req_funct3;
                    off_q <= off;
                    split_q <= split;
                    hi_mask_q <= req_store ? lanes[7:4] : 4'b0000;
                    hi_wdata_q <= shifted[2*WIDTH-1:WIDTH];
                    if (bad || misalign) begin
                        state <= RESP;
                        resp_valid <= 1'b1;
                        resp_err <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        state <= ACC0;
                        mem_req <= 1'b1;
                        mem_we <= req_store;
                        mem_addr <= {req_addr[WIDTH-1:2], 2'b00};
                        mem_wmask <= req_store ? lanes[3:0] : 4'b0000;
                        mem_wdata <= shifted[WIDTH-1:0];
                    end
                end
                ACC0, ACC1: if (mem_ack) begin
                    asm_q <= raw;
                    if (state == ACC0 && split_q) begin
                        state <= ACC1;
                        mem_addr <= mem_addr + WIDTH'(4);
                        mem_wmask <= hi_mask_q;
                        mem_wdata <= hi_wdata_q;
                    end else begin
                        state <= RESP;
                        mem_req <= 1'b0;
                        mem_we <= 1'b0;
                        mem_wmask <= 4'b0000;
                        resp_valid <= 1'b1;
                        resp_err <= 1'b0;
                        resp_rdata <= ext;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven directed checks plus reset-abort and idle-ack sequences.
module tb_load_store_unit;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_store = 1'b0, mem_ack = 1'b0;
    logic [2:0] req_funct3 = 3'b000;
    logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
    logic req_ready, resp_valid, resp_err, mem_req, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0] mem_wmask;
    int checks = 0, failures = 0;

    load_store_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic st;
        logic [2:0] f3;
        logic [31:0] addr, wdata;
        logic acc, split;
        int waits;
        logic [31:0] rd0, rd1, a0;
        logic [3:0] m0;
        logic [31:0] d0, a1;
        logic [3:0] m1;
        logic [31:0] d1, exp_rd;
        logic exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bytes(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = addr; v.wdata = '0;
        v.acc = 1'b1; v.split = 1'b0; v.waits = 0;
        v.rd0 = '0; v.rd1 = '0; v.a0 = addr & 32'hFFFF_FFFC; v.m0 = 4'b0000; v.d0 = '0;
        v.a1 = '0; v.m1 = 4'b0000; v.d1 = '0; v.exp_rd = '0; v.exp_err = 1'b0;
        return v;
    endfunction

    function automatic vec_t mk_ld(input logic [2:0] f3, input logic [31:0] addr, input int waits,
                                   input logic [31:0] rd0, input logic [31:0] exp_rd);
        vec_t v = mk(1'b0, f3, addr);
        v.waits = waits; v.rd0 = rd0; v.exp_rd = exp_rd;
        return v;
    endfunction

    function automatic vec_t mk_st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [3:0] m0, input logic [31:0] d0);
        vec_t v = mk(1'b1, f3, addr);
        v.wdata = wdata; v.m0 = m0; v.d0 = d0; v.rd0 = 32'h5A5A_5A5A;
        return v;
    endfunction

    function automatic vec_t mk_bad(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        vec_t v = mk(st, f3, addr);
        v.acc = 1'b0; v.exp_err = 1'b1; v.wdata = 32'h1234_ABCD;
        return v;
    endfunction

    task automatic run(input vec_t v, input int i);
        string t = $sformatf("v%0d", i);
        @(negedge clk);
        check({t, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_store = v.st; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        if (v.acc) begin
            for (int w = 0; w < v.waits; w++) begin
                check({t, "_wait_req"}, 32'(mem_req), 32'd1);
                check({t, "_wait_addr"}, mem_addr, v.a0);
                check({t, "_wait_resp"}, 32'(resp_valid), 32'd0);
                mem_rdata = 32'hDEAD_BEEF;
                @(negedge clk);
            end
            check({t, "_req0"}, 32'(mem_req), 32'd1);
            check({t, "_addr0"}, mem_addr, v.a0);
            check({t, "_mask0"}, 32'(mem_wmask), 32'(v.m0));
            check({t, "_we0"}, 32'(mem_we), 32'(v.st));
            if (v.st) check({t, "_wdata0"}, mem_wdata & bytes(v.m0), v.d0 & bytes(v.m0));
            mem_ack = 1'b1; mem_rdata = v.rd0;
            @(negedge clk);
            mem_ack = 1'b0;
            if (v.split) begin
                check({t, "_req1"}, 32'(mem_req), 32'd1);
                check({t, "_addr1"}, mem_addr, v.a1);
                check({t, "_mask1"}, 32'(mem_wmask), 32'(v.m1));
                check({t, "_resp_early"}, 32'(resp_valid), 32'd0);
                if (v.st) check({t, "_wdata1"}, mem_wdata & bytes(v.m1), v.d1 & bytes(v.m1));
                mem_ack = 1'b1; mem_rdata = v.rd1;
                @(negedge clk);
                mem_ack = 1'b0;
            end
        end
        check({t, "_resp_valid"}, 32'(resp_valid), 32'd1);
        check({t, "_rdata"}, resp_rdata, v.exp_rd);
        check({t, "_err"}, 32'(resp_err), 32'(v.exp_err));
        check({t, "_req_after"}, 32'(mem_req), 32'd0);
        @(negedge clk);
        check({t, "_resp_pulse"}, 32'(resp_valid), 32'd0);
        check({t, "_ready_again"}, 32'(req_ready), 32'd1);
        check({t, "_rdata_hold"}, resp_rdata, v.exp_rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs.push_back(mk_ld(3'b010, 32'h10, 0, 32'h8000_00FF, 32'h8000_00FF));
        vecs.push_back(mk_ld(3'b000, 32'h13, 0, 32'h8000_0000, 32'hFFFF_FF80));
        vecs.push_back(mk_ld(3'b100, 32'h13, 0, 32'h8000_0000, 32'h0000_0080));
        vecs.push_back(mk_st(3'b001, 32'h22, 32'h1234_ABCD, 4'b1100, 32'hABCD_0000));
        vecs.push_back(mk_st(3'b000, 32'h21, 32'h0000_00A5, 4'b0010, 32'h0000_A500));
        vecs.push_back(mk_st(3'b010, 32'h30, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D));
        vecs.push_back(mk_ld(3'b001, 32'h16, 0, 32'h8001_7FFF, 32'hFFFF_8001));
        vecs.push_back(mk_ld(3'b101, 32'h14, 0, 32'h1234_F00D, 32'h0000_F00D));
        vecs.push_back(mk_ld(3'b010, 32'h40, 2, 32'h0BAD_F00D, 32'h0BAD_F00D));
        vecs.push_back(mk_ld(3'b000, 32'h08, 1, 32'h0000_007F, 32'h0000_007F));
        vecs.push_back(mk_bad(1'b0, 3'b011, 32'h10));
        vecs.push_back(mk_bad(1'b0, 3'b110, 32'h10));
        vecs.push_back(mk_bad(1'b0, 3'b111, 32'h10));
        vecs.push_back(mk_bad(1'b1, 3'b100, 32'h10));
        vecs.push_back(mk_bad(1'b1, 3'b011, 32'h10));
`ifdef LSU_MISALIGN_SPLIT_EN
        v = mk_st(3'b010, 32'h1E, 32'h1234_ABCD, 4'b1100, 32'hABCD_0000);
        v.split = 1'b1; v.a1 = 32'h20; v.m1 = 4'b0011; v.d1 = 32'h0000_1234;
        vecs.push_back(v);
        v = mk_ld(3'b010, 32'hFFFF_FFFE, 0, 32'h5566_7788, 32'h3344_5566);
        v.split = 1'b1; v.a1 = 32'h0; v.rd1 = 32'h1122_3344;
        vecs.push_back(v);
        v = mk_ld(3'b010, 32'h13, 1, 32'hAA00_0000, 32'hDDCC_BBAA);
        v.split = 1'b1; v.a1 = 32'h14; v.rd1 = 32'h00DD_CCBB;
        vecs.push_back(v);
        v = mk_ld(3'b001, 32'h13, 0, 32'h8000_0000, 32'hFFFF_FF80);
        v.split = 1'b1; v.a1 = 32'h14; v.rd1 = 32'h0000_00FF;
        vecs.push_back(v);
        vecs.push_back(mk_ld(3'b001, 32'h11, 0, 32'h00AB_CD00, 32'hFFFF_ABCD));
        vecs.push_back(mk_st(3'b001, 32'h21, 32'h0000_BEEF, 4'b0110, 32'h00BE_EF00));
`else
        vecs.push_back(mk_bad(1'b1, 3'b010, 32'h1E));
        vecs.push_back(mk_bad(1'b0, 3'b010, 32'hFFFF_FFFE));
        vecs.push_back(mk_bad(1'b0, 3'b010, 32'h13));
        vecs.push_back(mk_bad(1'b0, 3'b001, 32'h13));
        vecs.push_back(mk_bad(1'b0, 3'b001, 32'h11));
        vecs.push_back(mk_bad(1'b1, 3'b001, 32'h21));
`endif
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        #1 check("post_rst_ready", 32'(req_ready), 32'd1);
        mem_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_ack_req", 32'(mem_req), 32'd0);
            check("idle_ack_resp", 32'(resp_valid), 32'd0);
        end
        mem_ack = 1'b0;
        foreach (vecs[i]) run(vecs[i], i);
        // reset while the memory is stalling on a load: no response may ever appear
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h50;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_wait1_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        check("abort_wait2_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_req_drop", 32'(mem_req), 32'd0);
        check("abort_addr_drop", mem_addr, 32'd0);
        check("abort_ready_low", 32'(req_ready), 32'd0);
        check("abort_rdata_clear", resp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("abort_ready_high", 32'(req_ready), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_resp", 32'(resp_valid), 32'd0);
            check("abort_no_req", 32'(mem_req), 32'd0);
        end
        mem_ack = 1'b0;
        run(mk_ld(3'b010, 32'h54, 0, 32'h7654_3210, 32'h7654_3210), 99);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface: accepts one load or store at a time from the execute stage and drives word-addressed requests to the data memory. It builds byte-lane write masks, shifts store data into the right lanes and sign- or zero-extends load data. Each transaction completes with a single-cycle response to the writeback path. It sits between the ALU address result and the data memory, replacing direct ALU-to-memory wiring.

## Interface
- WIDTH, 32, data/address width; only 32 is supported (4 byte lanes)
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  execute stage presents a transaction
- req_ready  out  1  unit can accept; high only in IDLE and while rst is low
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  WIDTH  byte address (ALU result)
- req_wdata  in  WIDTH  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  WIDTH  extended load data; 0 for stores and errors
- resp_err  out  1  illegal funct3 or unsupported misalignment
- mem_req  out  1  memory access request
- mem_we  out  1  write enable, qualified by mem_req
- mem_addr  out  WIDTH  word-aligned address (bits [1:0] = 00)
- mem_wmask  out  4  byte-lane write mask
- mem_wdata  out  WIDTH  lane-shifted store data
- mem_ack  in  1  memory completes the access in this cycle (may be the first mem_req cycle)
- mem_rdata  in  WIDTH  read word, valid in the mem_ack cycle

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: on req_valid && req_ready, latch the request. A legal request goes to ACC0. An illegal one goes to RESP with err=1 and no memory access.
- Illegal: load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
- Offset off = addr[1:0]; size sz = 1/2/4 bytes.
- ACC0: mem_req=1, mem_addr = addr & ~3, mem_wmask = lanes off..min(off+sz,4)-1, mem_wdata = wdata << 8*off.
  - mem_req, mem_addr, mem_wmask, mem_wdata and mem_we stay stable until mem_ack.
  - On ack, go to ACC1 if off+sz > 4, else to RESP.
- ACC1: mem_addr = (addr & ~3) + 4 (wraps mod 2^32), mem_wmask = lanes 0..off+sz-5, mem_wdata = wdata >> 8*(4-off). On ack, go to RESP.
- Load data is assembled from the read lanes: ACC0 word bytes off..3, then ACC1 bytes, into an internal register. The result is then sign-extended (B, H) or zero-extended (BU, HU) to 32 bits.
- RESP: resp_valid=1 for exactly one cycle with resp_rdata and resp_err. Next state is IDLE. resp_rdata holds its value until the next RESP.
- Loads keep mem_wmask = 0000 and mem_we = 0. Stores drive resp_rdata = 0.

## Timing
- Aligned access, zero-wait memory: accept at T, mem_req at T+1 (acked), resp_valid at T+2, req_ready high again at T+3.
- Each memory wait cycle adds one cycle. A split access adds at least one cycle.
- Illegal request: accept at T, resp_valid at T+1, no mem_req.
- Reset values: state IDLE; mem_req=0, mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0. req_ready=0 while rst is high.
- rst asserted mid-transaction: outputs drop to reset values immediately (asynchronous). The pending transaction is discarded with no response. A partial store already acked stays in memory.
- mem_ack while mem_req=0 is ignored.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined:
  - Misaligned accesses within one word complete in one access.
  - Word-crossing accesses split into ACC0 + ACC1 as above.
- Not defined:
  - Any access with addr not a multiple of sz goes directly to RESP with err=1 and no memory access.
  - ACC1 is not implemented.

## Test plan
- LW addr 0x10, mem_rdata 0x8000_00FF, zero-wait -> mem_req at T+1 with mem_addr 0x10; resp_valid at T+2, rdata 0x8000_00FF, err 0.
- LB addr 0x13, mem_rdata 0x80_00_00_00 -> rdata 0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH addr 0x22, wdata 0x1234_ABCD -> mem_addr 0x20, wmask 1100, mem_wdata 0xABCD_xxxx, mem_we 1; resp rdata 0.
- SW addr 0x1E with macro -> ACC0 addr 0x1C mask 1100 wdata[31:16]=0xABCD (for wdata 0x1234_ABCD); ACC1 addr 0x20 mask 0011 wdata[15:0]=0x1234. Without macro -> err 1, no mem_req.
- LW with 3 wait cycles, rst asserted on the 2nd wait cycle -> mem_req=0 immediately, no resp_valid, req_ready high the first cycle after rst deasserts.
- Load funct3 011 -> resp_valid at T+1, err 1, rdata 0, mem_req never asserted.
